// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and load results onto one register-file write port.
// MEM has fixed priority; define WB_ARB_STARVE_EN to enable the ALU starvation guard.
module wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int ADDR_SIZE  = 5,
  parameter int STARVE_MAX = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  input  logic [ADDR_SIZE-1:0] alu_rd,
  input  logic [XLEN-1:0]      alu_data,
  output logic                 alu_ready,
  input  logic                 mem_valid,
  input  logic [ADDR_SIZE-1:0] mem_rd,
  input  logic [XLEN-1:0]      mem_data,
  output logic                 mem_ready,
  output logic                 WB_we,
  output logic [ADDR_SIZE-1:0] WB_rd,
  output logic [XLEN-1:0]      WB_data_mem,
  output logic                 wb_src,
  output logic [15:0]          conflict_cnt
);

  logic force_alu;
  logic alu_gnt;
  logic mem_gnt;

  always_comb begin
    alu_ready = !rst && (!mem_valid || force_alu);
    mem_ready = !rst && !(alu_valid && force_alu);
    alu_gnt   = alu_valid && alu_ready;
    mem_gnt   = mem_valid && mem_ready;
  end

`ifdef WB_ARB_STARVE_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_q;
  logic [3:0] starve_d;

  assign force_alu = (starve_q == STARVE_LIM);

  // A pending, ungranted ALU result is exactly alu_valid && !alu_gnt.
  always_comb begin
    starve_d = starve_q;
    if (!alu_valid || alu_gnt) begin
      starve_d = 4'd0;
    end else if (starve_q != STARVE_LIM) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic [3:0] unused_starve_max;

  assign unused_starve_max = 4'(STARVE_MAX);
  assign force_alu         = 1'b0;
`endif

  logic                 we_q,   we_d;
  logic [ADDR_SIZE-1:0] rd_q,   rd_d;
  logic [XLEN-1:0]      data_q, data_d;
  logic                 src_q,  src_d;
  logic [15:0]          conf_q, conf_d;

  always_comb begin
    we_d   = 1'b0;
    rd_d   = rd_q;
    data_d = data_q;
    src_d  = src_q;
    unique case (1'b1)
      mem_gnt: begin
        we_d   = (mem_rd != '0);
        rd_d   = mem_rd;
        data_d = mem_data;
        src_d  = 1'b1;
      end
      alu_gnt: begin
        we_d   = (alu_rd != '0);
        rd_d   = alu_rd;
        data_d = alu_data;
        src_d  = 1'b0;
      end
      default: ;
    endcase
    conf_d = conf_q;
    if (alu_valid && mem_valid && conf_q != 16'hFFFF) begin
      conf_d = conf_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
      src_q  <= 1'b0;
      conf_q <= 16'd0;
    end else begin
      we_q   <= we_d;
      rd_q   <= rd_d;
      data_q <= data_d;
      src_q  <= src_d;
      conf_q <= conf_d;
    end
  end

  assign WB_we        = we_q;
  assign WB_rd        = rd_q;
  assign WB_data_mem  = data_q;
  assign wb_src       = src_q;
  assign conflict_cnt = conf_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter.
// Starvation expectations follow WB_ARB_STARVE_EN as seen by this compile.
module tb_wb_arbiter;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid, mem_valid;
  logic [AW-1:0]   alu_rd, mem_rd;
  logic [XLEN-1:0] alu_data, mem_data;
  logic            alu_ready, mem_ready;
  logic            WB_we, wb_src;
  logic [AW-1:0]   WB_rd;
  logic [XLEN-1:0] WB_data_mem;
  logic [15:0]     conflict_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(XLEN), .ADDR_SIZE(AW), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd),
    .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd),
    .mem_data(mem_data), .mem_ready(mem_ready),
    .WB_we(WB_we), .WB_rd(WB_rd),
    .WB_data_mem(WB_data_mem), .wb_src(wb_src),
    .conflict_cnt(conflict_cnt)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic exp_alu;

  initial begin
    rst = 1'b1;
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    mem_valid = 0; mem_rd = '0; mem_data = '0;
    tick();
    alu_valid = 1; mem_valid = 1;
    #1;
    check("rst_alu_rdy", 32'(alu_ready), 0);
    check("rst_mem_rdy", 32'(mem_ready), 0);
    tick();
    alu_valid = 0; mem_valid = 0;
    check("rst_we", 32'(WB_we), 0);
    check("rst_rd", 32'(WB_rd), 0);
    check("rst_data", WB_data_mem, 0);
    check("rst_src", 32'(wb_src), 0);
    check("rst_conf", 32'(conflict_cnt), 0);
    rst = 1'b0;

    alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
    #1;
    check("alu_rdy", 32'(alu_ready), 1);
    tick();
    alu_valid = 0;
    check("alu_we", 32'(WB_we), 1);
    check("alu_rd", 32'(WB_rd), 5);
    check("alu_data", WB_data_mem, 32'h1234);
    check("alu_src", 32'(wb_src), 0);
    tick();
    check("idle_we", 32'(WB_we), 0);
    check("idle_rd", 32'(WB_rd), 5);
    check("idle_data", WB_data_mem, 32'h1234);

    alu_valid = 1; alu_rd = 3; alu_data = 32'h3333;
    mem_valid = 1; mem_rd = 7; mem_data = 32'hAAAA;
    #1;
    check("col_mem_rdy", 32'(mem_ready), 1);
    check("col_alu_rdy", 32'(alu_ready), 0);
    tick();
    alu_valid = 0; mem_valid = 0;
    check("col_we", 32'(WB_we), 1);
    check("col_rd", 32'(WB_rd), 7);
    check("col_data", WB_data_mem, 32'hAAAA);
    check("col_src", 32'(wb_src), 1);
    check("col_conf", 32'(conflict_cnt), 1);

    alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF;
    #1;
    check("r0_rdy", 32'(alu_ready), 1);
    tick();
    alu_valid = 0;
    check("r0_we", 32'(WB_we), 0);
    check("r0_rd", 32'(WB_rd), 0);
    check("r0_data", WB_data_mem, 32'hFFFF);
    check("r0_src", 32'(wb_src), 0);

    alu_valid = 1; alu_rd = 2; alu_data = 32'h2;
    mem_valid = 1; mem_rd = 4; mem_data = 32'h4;
    for (int i = 0; i < 8; i++) begin
`ifdef WB_ARB_STARVE_EN
      exp_alu = (i % 4 == 3);
`else
      exp_alu = 1'b0;
`endif
      #1;
      check($sformatf("stv_alu_rdy%0d", i), 32'(alu_ready), 32'(exp_alu));
      check($sformatf("stv_mem_rdy%0d", i), 32'(mem_ready), 32'(!exp_alu));
      tick();
      check($sformatf("stv_src%0d", i), 32'(wb_src), 32'(!exp_alu));
      check($sformatf("stv_rd%0d", i), 32'(WB_rd), exp_alu ? 2 : 4);
    end
    alu_valid = 0; mem_valid = 0;
    check("stv_conf", 32'(conflict_cnt), 9);

    for (int i = 1; i <= 4; i++) begin
      alu_valid = 1; alu_rd = AW'(i); alu_data = 32'(i * 16);
      tick();
      check($sformatf("b2b_we%0d", i), 32'(WB_we), 1);
      check($sformatf("b2b_rd%0d", i), 32'(WB_rd), 32'(i));
      check($sformatf("b2b_data%0d", i), WB_data_mem, 32'(i * 16));
    end

    alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
    mem_valid = 1; mem_rd = 6; mem_data = 32'h66;
    tick();
    rst = 1'b1;
    #1;
    check("mid_alu_rdy", 32'(alu_ready), 0);
    check("mid_mem_rdy", 32'(mem_ready), 0);
    tick();
    check("mid_we", 32'(WB_we), 0);
    check("mid_rd", 32'(WB_rd), 0);
    check("mid_data", WB_data_mem, 0);
    check("mid_src", 32'(wb_src), 0);
    check("mid_conf", 32'(conflict_cnt), 0);
    rst = 1'b0;

    repeat (70000) @(posedge clk);
    #1;
    check("sat_conf", 32'(conflict_cnt), 32'hFFFF);
    repeat (5) tick();
    check("sat_hold", 32'(conflict_cnt), 32'hFFFF);
    alu_valid = 0; mem_valid = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter ADDR_SIZE, default 5, register index width.
REQ-003 SHALL have parameter STARVE_MAX, default 3, legal 1..15: ALU denial cycles before ALU is forced to win.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port alu_valid  input  1  ALU result pending.
REQ-007 SHALL have port alu_rd  input  ADDR_SIZE  ALU destination register.
REQ-008 SHALL have port alu_data  input  XLEN  ALU result.
REQ-009 SHALL have port alu_ready  output  1  ALU result accepted this cycle.
REQ-010 SHALL have port mem_valid  input  1  load result pending.
REQ-011 SHALL have port mem_rd  input  ADDR_SIZE  load destination register.
REQ-012 SHALL have port mem_data  input  XLEN  load data.
REQ-013 SHALL have port mem_ready  output  1  load result accepted this cycle.
REQ-014 SHALL have port WB_we  output  1  register-file write enable.
REQ-015 SHALL have port WB_rd  output  ADDR_SIZE  register-file write index.
REQ-016 SHALL have port WB_data_mem  output  XLEN  register-file write data.
REQ-017 SHALL have port wb_src  output  1  source of the last grant: 0 = ALU, 1 = MEM.
REQ-018 SHALL have port conflict_cnt  output  16  saturating count of cycles with both valids high.

Function
REQ-019 SHALL grant at most one requester per cycle; a grant is valid && ready on the same cycle.
REQ-020 SHALL compute ready combinationally from the current valids and the starvation state, with no dependency on WB_* outputs.
REQ-021 SHALL give MEM priority: mem_ready = !(alu_valid && force_alu); alu_ready = !mem_valid || force_alu.
REQ-022 SHALL compute force_alu = (starve_cnt == STARVE_MAX), where starve_cnt is a 4-bit internal counter.
REQ-023 SHALL increment starve_cnt (saturating at STARVE_MAX) on each cycle where alu_valid && !alu_ready.
REQ-024 SHALL clear starve_cnt on an ALU grant or whenever alu_valid is low.
REQ-025 SHALL register the granted rd and data onto WB_rd and WB_data_mem one cycle after the grant.
REQ-026 SHALL set WB_we = 1 in that cycle unless the granted rd == 0.
REQ-027 SHALL accept and drop a granted write with rd == 0: ready is asserted, WB_we stays 0, WB_rd and WB_data_mem still update.
REQ-028 SHALL drive WB_we = 0 in the cycle after a no-grant cycle, with WB_rd, WB_data_mem and wb_src holding their values.
REQ-029 SHALL update wb_src on every grant, including rd == 0 grants.
REQ-030 SHALL increment conflict_cnt on each cycle with alu_valid && mem_valid, saturating at 0xFFFF.
REQ-031 SHALL give a sustained 1-cycle throughput: back-to-back grants produce back-to-back WB_we pulses.
REQ-032 SHALL let an ALU grant caused by force_alu clear starve_cnt, so MEM wins again on the following cycle.

Reset
REQ-033 SHALL, while rst is high at posedge clk, clear WB_we, WB_rd, WB_data_mem, wb_src, starve_cnt and conflict_cnt to 0.
REQ-034 SHALL hold alu_ready = mem_ready = 0 while rst is high, so no grant occurs during reset.
REQ-035 SHALL discard any grant registered in the cycle rst rises; WB_we is 0 the cycle after.

Configuration
REQ-036 SHALL implement the starvation guard only when macro WB_ARB_STARVE_EN is defined.
REQ-037 SHALL, without WB_ARB_STARVE_EN, tie force_alu to 0, remove starve_cnt, and use pure fixed MEM priority; STARVE_MAX is then unused.

Verification
REQ-038 SHALL cover single ALU write: alu_valid=1, alu_rd=5, alu_data=0x1234 for 1 cycle -> alu_ready=1 that cycle; next cycle WB_we=1, WB_rd=5, WB_data_mem=0x1234, wb_src=0.
REQ-039 SHALL cover a collision: both valid, mem_rd=7, alu_rd=3 -> mem_ready=1, alu_ready=0; next cycle WB_rd=7, wb_src=1; conflict_cnt=1.
REQ-040 SHALL cover starvation with WB_ARB_STARVE_EN and STARVE_MAX=3: both valid continuously -> MEM granted cycles 0-2, ALU granted cycle 3, MEM cycles 4-6, ALU cycle 7; without the macro, ALU is never granted.
REQ-041 SHALL cover r0 drop: alu_valid=1, alu_rd=0, alu_data=0xFFFF -> alu_ready=1; next cycle WB_we=0, WB_rd=0.
REQ-042 SHALL cover reset mid-stream: rst=1 asserted during continuous grants -> readys 0 immediately; after the clock, all outputs 0 and conflict_cnt=0.
REQ-043 SHALL cover conflict saturation: both valid for 70000 cycles -> conflict_cnt=0xFFFF and holds.
